// File: rtl/dm_access_ctrl_if.sv
// CPU load/store and data-memory bus bundle for dm_access_ctrl.
// The slave modport is the controller's view; master is the CPU plus memory side.
interface dm_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              misalign;
    logic              busy;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_datain;
    logic              dm_str;
    logic [31:0]       dm_dataout;

    modport master (
        output req, we, size, sign_ext, cpu_addr, cpu_wdata, dm_dataout,
        input  ack, rdata, misalign, busy, dm_addr, dm_datain, dm_str
    );

    modport slave (
        input  req, we, size, sign_ext, cpu_addr, cpu_wdata, dm_dataout,
        output ack, rdata, misalign, busy, dm_addr, dm_datain, dm_str
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: word accesses direct, sub-word stores via
// read-modify-write, sub-word loads lane-extracted and sign/zero-extended.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic            clk,
    input  logic            clr,
    dm_access_ctrl_if.slave bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic [1:0]        size_q,     size_d;
    logic              sext_q,     sext_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       rdata_q,    rdata_d;

    logic        req_misalign;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_misalign = (bus.size == 2'b11)
                        || ((bus.size == SZ_HALF) && bus.cpu_addr[0])
                        || ((bus.size == SZ_WORD) && (bus.cpu_addr[1:0] != 2'b00));

    // Lane extraction and extension of the word currently read from memory.
    always_comb begin
        byte_v = bus.dm_dataout[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? bus.dm_dataout[31:16] : bus.dm_dataout[15:0];
        unique case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & byte_v[7]}}, byte_v};
            SZ_HALF: load_val = {{16{sext_q & half_v[15]}}, half_v};
            default: load_val = bus.dm_dataout;
        endcase
    end

    // Read word with the store lane(s) replaced by right-aligned store data.
    always_comb begin
        merged = bus.dm_dataout;
        unique case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        misalign_d = misalign_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d     = bus.cpu_addr;
                    wdata_d    = bus.cpu_wdata;
                    we_d       = bus.we;
                    size_d     = bus.size;
                    sext_d     = bus.sign_ext;
                    misalign_d = req_misalign;
                    if (req_misalign)                          state_d = S_DONE;
                    else if (bus.we && (bus.size == SZ_WORD))  state_d = S_WRITE;
                    else                                       state_d = S_READ;
                end
            end
            S_READ: begin
                // wdata_q doubles as the merge buffer, so WRITE drives it directly.
                if (we_q) begin
                    wdata_d = merged;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
        end
    end

    // Strobe and handshake are pure state decodes so a reset drops them at once.
    assign bus.ack       = (state_q == S_DONE);
    assign bus.misalign  = (state_q == S_DONE) && misalign_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dm_str    = (state_q == S_WRITE);
    assign bus.dm_addr   = addr_q;
    assign bus.dm_datain = wdata_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a word-wide memory model.
module tb_dm_access_ctrl;
    logic clk;
    logic clr;
    int   n_checks = 0;
    int   n_pass   = 0;

    dm_access_ctrl_if #(.ADDR_W(32)) bus ();

    dm_access_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [31:0] mem [0:1023];

    assign bus.dm_dataout = mem[bus.dm_addr[11:2]];

    always @(posedge clk) begin
        if (bus.dm_str) mem[bus.dm_addr[11:2]] <= bus.dm_datain;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one request; report ack cycle (-1 if none), strobe count, misalign, rdata.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int ack_cyc, output int strobes,
                           output logic mis, output logic [31:0] rd);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.cpu_addr = a; bus.cpu_wdata = wd;
        @(posedge clk);
        #1 bus.req = 1'b0;
        ack_cyc = -1; strobes = 0; mis = 1'b0; rd = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.dm_str) strobes++;
            if (bus.ack) begin
                ack_cyc = n; mis = bus.misalign; rd = bus.rdata;
                break;
            end
        end
    endtask

    initial begin
        int          ac;
        int          st;
        int          acks;
        logic        mi;
        logic [31:0] rd;
        logic [31:0] exp_rd;

        clr = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        #2;
        check("rst_ack",      32'(bus.ack),      32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_str",      32'(bus.dm_str),   32'd0);
        check("rst_misalign", 32'(bus.misalign), 32'd0);
        check("rst_rdata",    bus.rdata,         32'h0);
        check("rst_dm_addr",  bus.dm_addr,       32'h0);
        check("rst_datain",   bus.dm_datain,     32'h0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // Word store then word load at 0x10.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ac, st, mi, rd);
        check("wst_ack_cyc", 32'(ac), 32'd2);
        check("wst_strobes", 32'(st), 32'd1);
        check("wst_mis",     32'(mi), 32'd0);
        check("wst_rdata",   rd,      32'h0);
        check("wst_mem",     mem[4],  32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ac, st, mi, rd);
        check("wld_ack_cyc", 32'(ac), 32'd2);
        check("wld_strobes", 32'(st), 32'd0);
        check("wld_mis",     32'(mi), 32'd0);
        check("wld_rdata",   rd,      32'hDEADBEEF);

        // Byte store read-modify-write.
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, ac, st, mi, rd);
        check("bst_ack_cyc", 32'(ac), 32'd3);
        check("bst_strobes", 32'(st), 32'd1);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ac, st, mi, rd);
        check("bst_readback", rd, 32'hDEAD5AEF);

        // Sub-word loads with extension.
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, ac, st, mi, rd);
        check("lb13_sx_ack", 32'(ac), 32'd2);
        check("lb13_sx",     rd,      32'hFFFFFFDE);
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, ac, st, mi, rd);
        check("lb13_zx",     rd,      32'h000000DE);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, ac, st, mi, rd);
        check("lb11_sx_pos", rd,      32'h0000005A);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, ac, st, mi, rd);
        check("lh12_sx",     rd,      32'hFFFFDEAD);
        run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, ac, st, mi, rd);
        check("lh10_zx",     rd,      32'h00005AEF);

        // Misaligned requests: ack in cycle 1, no write, rdata held.
        run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, ac, st, mi, rd);
        check("mis_sh_ack",   32'(ac), 32'd1);
        check("mis_sh_flag",  32'(mi), 32'd1);
        check("mis_sh_str",   32'(st), 32'd0);
        check("mis_sh_rdata", rd,      32'h00005AEF);
        check("mis_sh_mem",   mem[4],  32'hDEAD5AEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, ac, st, mi, rd);
        check("mis_lw_ack",   32'(ac), 32'd1);
        check("mis_lw_flag",  32'(mi), 32'd1);
        check("mis_lw_rdata", rd,      32'h00005AEF);
        run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEF00D, ac, st, mi, rd);
        check("mis_sz3_ack",  32'(ac), 32'd1);
        check("mis_sz3_flag", 32'(mi), 32'd1);
        check("mis_sz3_str",  32'(st), 32'd0);
        check("mis_sz3_mem",  mem[4],  32'hDEAD5AEF);

        // Preload words for the reset and streaming tests.
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, ac, st, mi, rd);
        run_req(1'b1, 2'b10, 1'b0, 32'h00, 32'hA0A0A0A0, ac, st, mi, rd);
        run_req(1'b1, 2'b10, 1'b0, 32'h04, 32'hB1B1B1B1, ac, st, mi, rd);
        check("preload_mem8", mem[8], 32'h11111111);

        // Reset asserted while a half store sits in READ.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b01; bus.sign_ext = 1'b0;
        bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h00001234;
        @(posedge clk);
        #1 bus.req = 1'b0;
        check("rmw_busy_pre", 32'(bus.busy), 32'd1);
        clr = 1'b0;
        #1;
        check("mid_rst_busy",   32'(bus.busy),   32'd0);
        check("mid_rst_ack",    32'(bus.ack),    32'd0);
        check("mid_rst_str",    32'(bus.dm_str), 32'd0);
        check("mid_rst_addr",   bus.dm_addr,     32'h0);
        check("mid_rst_datain", bus.dm_datain,   32'h0);
        check("mid_rst_rdata",  bus.rdata,       32'h0);
        st = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dm_str) st++;
        end
        check("mid_rst_strobes", 32'(st), 32'd0);
        check("mid_rst_mem",     mem[8],  32'h11111111);
        clr = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ac, st, mi, rd);
        check("post_rst_ack",   32'(ac), 32'd2);
        check("post_rst_rdata", rd,      32'h11111111);

        // Upper-half store completes normally after reset.
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, ac, st, mi, rd);
        check("sh22_ack_cyc", 32'(ac), 32'd3);
        check("sh22_strobes", 32'(st), 32'd1);
        check("sh22_mem",     mem[8],  32'hBEEF1111);

        // req held high: loads at 0x0, 0x4, 0x0, ... one ack every 3 cycles.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.cpu_addr = 32'h0;
        acks = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("hold_busy_c%0d", c), 32'(bus.busy), 32'((c % 3) != 0));
            check($sformatf("hold_ack_c%0d", c),  32'(bus.ack),  32'((c % 3) == 2));
            if (bus.ack) begin
                acks++;
                exp_rd = (((c / 3) % 2) != 0) ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
                check($sformatf("hold_rdata_c%0d", c), bus.rdata, exp_rd);
            end
            if ((c % 3) == 0) bus.cpu_addr = (((c / 3) % 2) != 0) ? 32'h4 : 32'h0;
        end
        bus.req = 1'b0;
        check("hold_ack_count", 32'(acks), 32'd3);
        repeat (3) @(negedge clk);
        check("hold_drain_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
